// File: rtl/prompt_pkg.sv
// Shared definitions for the countdown prompt sequencer: FSM states, default raster
// tick point and the bit position of each prompt enable.
package prompt_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StShow3,
    StShow2,
    StShow1,
    StGo
  } state_e;

  // First blanking line, leftmost column.
  localparam int unsigned TickHDefault = 0;
  localparam int unsigned TickVDefault = 480;

  localparam int unsigned NumPrompts = 4;
  localparam int unsigned PromptG3   = 0;
  localparam int unsigned PromptG2   = 1;
  localparam int unsigned PromptG1   = 2;
  localparam int unsigned PromptGo   = 3;

  function automatic logic [NumPrompts-1:0] prompt_enables(input state_e st);
    logic [NumPrompts-1:0] en;
    en = '0;
    case (st)
      StShow3: en[PromptG3] = 1'b1;
      StShow2: en[PromptG2] = 1'b1;
      StShow1: en[PromptG1] = 1'b1;
      StGo:    en[PromptGo] = 1'b1;
      default: en = '0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/frame_tick.sv
// One-cycle tick on the first clk at which the raster sits on the configured point;
// the point is held for a whole pixel, which spans several clks.
module frame_tick
  import prompt_pkg::*;
#(
  parameter int unsigned TICK_H = TickHDefault,
  parameter int unsigned TICK_V = TickVDefault
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  output logic       tick
);

  logic at_pt;
  logic at_pt_q;

  assign at_pt = (hCount == 10'(TICK_H)) && (vCount == 10'(TICK_V));

  // Resets high so a reset released on the tick point does not fire a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      at_pt_q <= 1'b1;
    end else begin
      at_pt_q <= at_pt;
    end
  end

  assign tick = at_pt && !at_pt_q;

endmodule

// File: rtl/prompt_sequencer.sv
// Frame-aligned "3", "2", "1", "GO" countdown driving the prompt overlay enables,
// with a GO pulse for the reaction timer and a done pulse on normal completion.
module prompt_sequencer
  import prompt_pkg::*;
#(
  parameter int unsigned FRAMES_PER_STEP = 60,
  parameter int unsigned GO_FRAMES       = 30,
  parameter int unsigned TICK_H          = TickHDefault,
  parameter int unsigned TICK_V          = TickVDefault
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic       start,
  input  logic       abort,
  output logic       en_g3,
  output logic       en_g2,
  output logic       en_g1,
  output logic       en_go,
  output logic       go_pulse,
  output logic       done,
  output logic       busy
);

  localparam logic [7:0] StepLast = 8'(FRAMES_PER_STEP - 1);
  localparam logic [7:0] GoLast   = 8'(GO_FRAMES - 1);

  state_e                state_q, state_d;
  logic [7:0]            fcnt_q, fcnt_d;
  logic [NumPrompts-1:0] en_q, en_d;
  logic                  go_pulse_q, go_pulse_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  tick;

  frame_tick #(
    .TICK_H (TICK_H),
    .TICK_V (TICK_V)
  ) u_frame_tick (
    .clk    (clk),
    .rst    (rst),
    .hCount (hCount),
    .vCount (vCount),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      fcnt_q     <= '0;
      en_q       <= '0;
      go_pulse_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      en_q       <= en_d;
      go_pulse_q <= go_pulse_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (abort) begin
      state_d = StIdle;
      fcnt_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StArm;
            fcnt_d  = '0;
          end
        end
        StArm: begin
          if (tick) begin
            state_d = StShow3;
            fcnt_d  = '0;
          end
        end
        StShow3, StShow2, StShow1: begin
          if (tick) begin
            if (fcnt_q == StepLast) begin
              state_d = (state_q == StShow3) ? StShow2 :
                        (state_q == StShow2) ? StShow1 : StGo;
              fcnt_d  = '0;
            end else begin
              fcnt_d = fcnt_q + 8'd1;
            end
          end
        end
        StGo: begin
          if (tick) begin
            if (fcnt_q == GoLast) begin
              state_d = StIdle;
              fcnt_d  = '0;
            end else begin
              fcnt_d = fcnt_q + 8'd1;
            end
          end
        end
        default: begin
          state_d = StIdle;
          fcnt_d  = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register on the same edge.
  always_comb begin
    en_d       = prompt_enables(state_d);
    busy_d     = (state_d != StIdle);
    go_pulse_d = (state_q == StShow1) && (state_d == StGo);
    done_d     = (state_q == StGo) && (state_d == StIdle) && !abort;
  end

  assign en_g3    = en_q[PromptG3];
  assign en_g2    = en_q[PromptG2];
  assign en_g1    = en_q[PromptG1];
  assign en_go    = en_q[PromptGo];
  assign go_pulse = go_pulse_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_prompt_sequencer.sv
// Randomized scoreboard bench for prompt_sequencer: a frame-counting reference model
// queues every expected output change with its cycle; a monitor pops on each DUT change.
module tb_prompt_sequencer;

  localparam int unsigned F  = 2;
  localparam int unsigned G  = 3;
  localparam int unsigned TH = 0;
  localparam int unsigned TV = 480;
  localparam int FrameClks   = 16 * 8 * 4;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [9:0] h, v;
  int         sub;
  logic       en_g3, en_g2, en_g1, en_go, go_pulse, done, busy;
  logic [6:0] dut_vec;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned cyc;
    logic [6:0]  vec;
  } ev_t;
  ev_t         exp_q[$];
  int unsigned cyc = 0;

  always #5 clk = ~clk;

  assign dut_vec = {busy, en_g3, en_g2, en_g1, en_go, go_pulse, done};

  prompt_sequencer #(
    .FRAMES_PER_STEP (F),
    .GO_FRAMES       (G),
    .TICK_H          (TH),
    .TICK_V          (TV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .hCount   (h),
    .vCount   (v),
    .start    (start),
    .abort    (abort),
    .en_g3    (en_g3),
    .en_g2    (en_g2),
    .en_g1    (en_g1),
    .en_go    (en_go),
    .go_pulse (go_pulse),
    .done     (done),
    .busy     (busy)
  );

  // Compressed raster: 8 columns, lines 0-3, 100-103, 476-483; one pixel per 4 clks.
  function automatic logic [9:0] next_line(input logic [9:0] cur);
    if (cur == 10'd3)   return 10'd100;
    if (cur == 10'd103) return 10'd476;
    if (cur == 10'd483) return 10'd0;
    return cur + 10'd1;
  endfunction

  initial begin
    h = '0; v = '0; sub = 0;
    forever begin
      @(negedge clk);
      sub = sub + 1;
      if (sub == 4) begin
        sub = 0;
        if (h == 10'd7) begin
          h = '0;
          v = next_line(v);
        end else begin
          h = h + 10'd1;
        end
      end
    end
  end

  // Reference model: counts frames since arming and maps the count onto prompts.
  initial begin : model
    bit         active, tk, gp, dn, rst_prev;
    int         n;
    logic [6:0] vec, prev;
    active = 0; n = 0; rst_prev = 1; prev = '0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      tk = (sub == 0) && (h == 10'(TH)) && (v == 10'(TV)) && !rst && !rst_prev;
      gp = 0; dn = 0;
      if (rst || abort) begin
        active = 0;
      end else if (!active) begin
        if (start) begin
          active = 1;
          n = 0;
        end
      end else if (tk) begin
        n = n + 1;
        if (n == 3 * F + 1) gp = 1;
        if (n > 3 * F + G) begin
          active = 0;
          dn = 1;
        end
      end
      vec = {active,
             active && n >= 1         && n <= F,
             active && n >= F + 1     && n <= 2 * F,
             active && n >= 2 * F + 1 && n <= 3 * F,
             active && n >= 3 * F + 1 && n <= 3 * F + G,
             gp, dn};
      rst_prev = rst;
      if (vec != prev) exp_q.push_back('{cyc, vec});
      prev = vec;
    end
  end

  initial begin : monitor
    logic [6:0] dprev;
    ev_t        e;
    dprev = '0;
    forever begin
      @(negedge clk);
      if (cyc >= 2) begin
        if (dut_vec !== dprev) begin
          checks = checks + 1;
          if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_change cyc=%0d got=%b prev=%b", cyc, dut_vec, dprev);
          end else begin
            e = exp_q.pop_front();
            if (e.vec !== dut_vec || e.cyc != cyc) begin
              errors = errors + 1;
              $display("FAIL event got=%b at cyc %0d, expected=%b at cyc %0d",
                       dut_vec, cyc, e.vec, e.cyc);
            end
          end
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL missed_event expected=%b at cyc %0d, got=%b", exp_q[0].vec,
                   exp_q[0].cyc, dut_vec);
          void'(exp_q.pop_front());
        end
      end
      dprev = dut_vec;
    end
  end

  initial begin : onehot_chk
    forever begin
      @(negedge clk);
      if (cyc >= 2) begin
        assert ($onehot0(dut_vec[5:2])) else begin
          errors = errors + 1;
          $display("FAIL onehot enables=%b required at most one high", dut_vec[5:2]);
        end
        assert (!go_pulse || en_go) else begin
          errors = errors + 1;
          $display("FAIL go_pulse_without_en_go go_pulse=%b en_go=%b", go_pulse, en_go);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_point(input logic [9:0] lv, input logic [9:0] lh);
    for (int i = 0; i < 3 * FrameClks; i++) begin
      if (v == lv && h == lh) return;
      step(1);
    end
    checks = checks + 1;
    errors = errors + 1;
    $display("FAIL wait_point timeout got v=%0d h=%0d required v=%0d h=%0d", v, h, lv, lh);
  endtask

  task automatic wait_out(input int idx, input logic val, input string name);
    for (int i = 0; i < 13 * FrameClks; i++) begin
      if (dut_vec[idx] === val) return;
      step(1);
    end
    checks = checks + 1;
    errors = errors + 1;
    $display("FAIL wait_%s timeout got=%b required=%b", name, dut_vec[idx], val);
  endtask

  task automatic check_vec(input string name, input logic [6:0] required);
    checks = checks + 1;
    if (dut_vec !== required) begin
      errors = errors + 1;
      $display("FAIL %s got=%b required=%b", name, dut_vec, required);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic run_full(input int max_delay);
    wait_point(10'd100, 10'd0);
    step($urandom_range(0, max_delay));
    pulse_start();
    wait_out(6, 1'b1, "busy_rise");
    wait_out(6, 1'b0, "busy_fall");
    step(4);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    step(5);

    // Release reset while the raster sits on the tick point.
    wait_point(10'(TV), 10'(TH));
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(2);
      check_vec("reset_idle", 7'b0);
    end

    run_full(40);

    // Abort in the second frame of "2".
    wait_point(10'd100, 10'd0);
    pulse_start();
    wait_out(4, 1'b1, "en_g2");
    step($urandom_range(FrameClks + 8, 2 * FrameClks - 8));
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check_vec("abort_clears", 7'b0);
    step(2 * FrameClks);

    // Repeated start during "1" must not disturb the sequence.
    wait_point(10'd100, 10'd0);
    pulse_start();
    wait_out(3, 1'b1, "en_g1");
    repeat (3) begin
      step($urandom_range(1, 250));
      pulse_start();
    end
    wait_out(6, 1'b0, "busy_fall");
    step(3);

    start = 1'b1;
    abort = 1'b1;
    step(1);
    start = 1'b0;
    abort = 1'b0;
    check_vec("start_abort_idle", 7'b0);
    step(3);
    check_vec("start_abort_idle_later", 7'b0);

    // Reset during GO, then a clean sequence.
    wait_point(10'd100, 10'd0);
    pulse_start();
    wait_out(2, 1'b1, "en_go");
    step($urandom_range(5, 400));
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_vec("reset_mid_run", 7'b0);
    run_full(40);

    for (int r = 0; r < 3; r++) run_full(FrameClks);

    step(20);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL pending_events got=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
